// File: rtl/uart_tx_prescaled.sv
// ---------------------------------------------------------------------------
// uart_tx_prescaled
//   Serial UART transmitter. One word is accepted per DATA_VALID handshake
//   while idle and sent as: start (0), DATA_WIDTH data bits LSB first,
//   optional parity bit, stop (1). Every bit is held for Prescale clk cycles.
//   A latched Prescale of 0 behaves as 1.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous reset, active-high (aborts any frame in flight)
//   P_DATA     word to transmit, latched on acceptance
//   DATA_VALID transmit request, honoured only when busy is low
//   PAR_EN     1 = append parity bit (latched on acceptance)
//   PAR_TYP    0 = XOR of data bits, 1 = XNOR of data bits (latched)
//   Prescale   clk cycles per bit (latched on acceptance)
//   TX_OUT     registered serial line, idle high
//   busy       high from the cycle after acceptance through the last stop cycle
// ---------------------------------------------------------------------------
module uart_tx_prescaled #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      DATA_VALID,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  output logic                      TX_OUT,
  output logic                      busy
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                    state_q;
  logic [PRESCALE_WIDTH-1:0] cnt_q;
  logic [PRESCALE_WIDTH-1:0] last_q;     // terminal count = Prescale-1
  logic [IDX_W-1:0]          idx_q;
  logic [DATA_WIDTH-1:0]     data_q;
  logic                      par_en_q;
  logic                      par_typ_q;
  logic                      tx_q;
  logic                      busy_q;

  logic                      bit_end;
  logic                      last_bit;
  logic [IDX_W-1:0]          idx_nxt;

  // Terminal count of the bit-time counter; a zero Prescale is folded to 1.
  function automatic logic [PRESCALE_WIDTH-1:0] last_count(
    input logic [PRESCALE_WIDTH-1:0] p
  );
    return (p == '0) ? '0 : p - 1'b1;
  endfunction

  // XOR of the data bits, inverted when the XNOR rule is selected.
  function automatic logic parity_of(
    input logic [DATA_WIDTH-1:0] d,
    input logic                  typ
  );
    return (^d) ^ typ;
  endfunction

  assign bit_end  = (cnt_q == last_q);
  assign last_bit = (idx_q == IDX_W'(DATA_WIDTH - 1));
  assign idx_nxt  = idx_q + 1'b1;

  // TX_OUT is loaded together with the state that owns the new bit, so the
  // line changes on the same edge the state changes and stays registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else if (state_q == IDLE) begin
      cnt_q <= '0;
      idx_q <= '0;
      if (DATA_VALID) begin
        data_q    <= P_DATA;
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
        last_q    <= last_count(Prescale);
        state_q   <= START;
        tx_q      <= 1'b0;
        busy_q    <= 1'b1;
      end
    end else begin
      cnt_q <= bit_end ? '0 : cnt_q + 1'b1;
      if (bit_end) begin
        case (state_q)
          START: begin
            state_q <= DATA;
            idx_q   <= '0;
            tx_q    <= data_q[0];
          end
          DATA: begin
            if (!last_bit) begin
              idx_q <= idx_nxt;
              tx_q  <= data_q[idx_nxt];
            end else if (par_en_q) begin
              state_q <= PARITY;
              tx_q    <= parity_of(data_q, par_typ_q);
            end else begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end
          end
          PARITY: begin
            state_q <= STOP;
            tx_q    <= 1'b1;
          end
          STOP: begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign TX_OUT = tx_q;
  assign busy   = busy_q;

endmodule
